// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI constants and parser state encoding for the voice allocator.
package midi_voice_allocator_pkg;

  localparam logic [3:0] MSG_NOTE_OFF = 4'h8;
  localparam logic [3:0] MSG_NOTE_ON  = 4'h9;
  localparam logic [3:0] MSG_CC       = 4'hB;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parser_state_t;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic is_one_byte_msg(input logic [3:0] kind);
    return (kind == 4'hC) || (kind == 4'hD);
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status; strobes each completed channel message.
module midi_byte_parser
  import midi_voice_allocator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       event_valid,
  output logic [3:0] event_type,
  output logic [3:0] event_channel,
  output logic [6:0] event_d1,
  output logic [6:0] event_d2
);

  parser_state_t state_reg;
  logic [7:0]    status_reg;
  logic [6:0]    d1_reg;
  logic          data_byte;

  assign data_byte = din_valid && !din[7];

  // The strobe is combinational on the completing byte so the voice state
  // can register it on the same edge.
  assign event_valid   = data_byte && !rst &&
                         ((state_reg == WAIT_D2) ||
                          ((state_reg == WAIT_D1) && is_one_byte_msg(status_reg[7:4])));
  assign event_type    = status_reg[7:4];
  assign event_channel = status_reg[3:0];
  assign event_d1      = (state_reg == WAIT_D2) ? d1_reg : din[6:0];
  assign event_d2      = din[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      status_reg <= 8'h00;
      d1_reg     <= 7'h00;
    end else if (din_valid) begin
      if (din[7]) begin
        if (din[7:4] != 4'hF) begin
          status_reg <= din;
          state_reg  <= WAIT_D1;
        end else if (!din[3]) begin
          status_reg <= 8'h00;
          state_reg  <= IDLE;
        end
        // 0xF8-0xFF real-time bytes fall through untouched.
      end else begin
        case (state_reg)
          WAIT_D1: begin
            d1_reg    <= din[6:0];
            state_reg <= is_one_byte_msg(status_reg[7:4]) ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: state_reg <= WAIT_D1;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: note on/off to per-voice note, velocity and gate with LRU stealing.
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              din,
  input  logic                    din_valid,
  output logic [NUM_VOICES*8-1:0] voice_note,
  output logic [NUM_VOICES*8-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_gate
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam logic [3:0] CHANNEL = MIDI_CHANNEL[3:0];

  logic       ev_valid;
  logic [3:0] ev_type;
  logic [3:0] ev_channel;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;

  midi_byte_parser u_parser (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .din_valid     (din_valid),
    .event_valid   (ev_valid),
    .event_type    (ev_type),
    .event_channel (ev_channel),
    .event_d1      (ev_d1),
    .event_d2      (ev_d2)
  );

  logic [6:0]            note_reg  [NUM_VOICES];
  logic [6:0]            note_next [NUM_VOICES];
  logic [6:0]            vel_reg   [NUM_VOICES];
  logic [6:0]            vel_next  [NUM_VOICES];
  logic [RW-1:0]         rank_reg  [NUM_VOICES];
  logic [RW-1:0]         rank_next [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_reg, gate_next;
  logic [NUM_VOICES-1:0] pend_reg, pend_next;

  logic          accept, note_on, note_off, all_off;
  logic          hit, free, steal;
  logic [RW-1:0] hit_idx, free_idx, oldest_idx, sel;

  assign accept   = ev_valid && ((OMNI != 0) || (ev_channel == CHANNEL));
  assign note_on  = (ev_type == MSG_NOTE_ON) && (ev_d2 != 7'd0);
  assign note_off = (ev_type == MSG_NOTE_OFF) || ((ev_type == MSG_NOTE_ON) && (ev_d2 == 7'd0));
  assign all_off  = (ev_type == MSG_CC) &&
                    ((ev_d1 == CC_ALL_SOUND_OFF) || (ev_d1 == CC_ALL_NOTES_OFF));

  always_comb begin
    hit        = 1'b0;
    free       = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    oldest_idx = '0;
    // Scan downwards so the lowest matching index wins.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_reg[i] && (note_reg[i] == ev_d1)) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
      if (!gate_reg[i] && !pend_reg[i]) begin
        free     = 1'b1;
        free_idx = RW'(i);
      end
      if (rank_reg[i] == RW'(NUM_VOICES - 1)) oldest_idx = RW'(i);
    end
    steal = !hit && !free;
    sel   = hit ? hit_idx : (free ? free_idx : oldest_idx);
  end

  always_comb begin
    gate_next = gate_reg;
    pend_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_next[i] = note_reg[i];
      vel_next[i]  = vel_reg[i];
      rank_next[i] = rank_reg[i];
      if (pend_reg[i]) gate_next[i] = 1'b1;
    end

    if (accept && note_on) begin
      note_next[sel] = ev_d1;
      vel_next[sel]  = ev_d2;
      gate_next[sel] = !steal;
      pend_next[sel] = steal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (RW'(i) == sel)                    rank_next[i] = '0;
        else if (rank_reg[i] < rank_reg[sel]) rank_next[i] = rank_reg[i] + RW'(1);
      end
    end

    if (accept && note_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if ((gate_reg[i] || pend_reg[i]) && (note_reg[i] == ev_d1)) begin
          gate_next[i] = 1'b0;
          pend_next[i] = 1'b0;
        end
      end
    end

    if (accept && all_off) begin
      gate_next = '0;
      pend_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_reg <= '0;
      pend_reg <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_reg[i] <= 7'd0;
        vel_reg[i]  <= 7'd0;
        rank_reg[i] <= RW'(NUM_VOICES - 1 - i);
      end
    end else begin
      gate_reg <= gate_next;
      pend_reg <= pend_next;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_reg[i] <= note_next[i];
        vel_reg[i]  <= vel_next[i];
        rank_reg[i] <= rank_next[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
    assign voice_note[8*gi +: 8]     = {1'b0, note_reg[gi]};
    assign voice_velocity[8*gi +: 8] = {vel_reg[gi], 1'b0};
  end
  assign voice_gate = gate_reg;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench: expected voice snapshots are queued with the stimulus and popped as outputs appear.
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;

  logic [31:0] note0, vel0, note1, vel1;
  logic [3:0]  gate0, gate1;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [3:0]  gate;
    logic [31:0] note;
    logic [31:0] vel;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  midi_voice_allocator #(.NUM_VOICES(4), .MIDI_CHANNEL(0), .OMNI(1)) dut_omni (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .voice_note(note0), .voice_velocity(vel0), .voice_gate(gate0)
  );

  midi_voice_allocator #(.NUM_VOICES(4), .MIDI_CHANNEL(1), .OMNI(0)) dut_ch1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .voice_note(note1), .voice_velocity(vel1), .voice_gate(gate1)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic send(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] g,
                              input logic [31:0] n, input logic [31:0] v);
    snap_t s;
    s.gate = g;
    s.note = n;
    s.vel  = v;
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  // One expected snapshot per cycle, starting at the current sample point.
  task automatic drain();
    snap_t s;
    string t;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("txn %s: gate=%h note=%h vel=%h", t, gate0, note0, vel0);
      check_value({t, "_gate"}, {28'd0, gate0}, {28'd0, s.gate});
      check_value({t, "_note"}, note0, s.note);
      check_value({t, "_vel"},  vel0,  s.vel);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_state("reset", 4'h0, 32'h0, 32'h0);
    drain();

    send(8'h90); send(8'h3C); send(8'h64);
    expect_state("first_note", 4'h1, 32'h0000003C, 32'h000000C8);
    drain();

    send(8'h40); send(8'h64);
    expect_state("running_v1", 4'h3, 32'h0000403C, 32'h0000C8C8);
    drain();
    send(8'h43); send(8'h64);
    expect_state("running_v2", 4'h7, 32'h0043403C, 32'h00C8C8C8);
    drain();
    send(8'h44); send(8'h64);
    expect_state("running_v3", 4'hF, 32'h4443403C, 32'hC8C8C8C8);
    drain();

    send(8'h90); send(8'h48); send(8'h64);
    expect_state("steal_low",  4'hE, 32'h44434048, 32'hC8C8C8C8);
    expect_state("steal_high", 4'hF, 32'h44434048, 32'hC8C8C8C8);
    drain();

    send(8'h90); send(8'h40); send(8'hF8);
    expect_state("realtime_mid", 4'hF, 32'h44434048, 32'hC8C8C8C8);
    drain();
    send(8'h00);
    expect_state("vel0_off", 4'hD, 32'h44434048, 32'hC8C8C8C8);
    drain();

    send(8'h90); send(8'h43); send(8'h50);
    expect_state("same_note", 4'hD, 32'h44434048, 32'hC8A0C8C8);
    drain();

    send(8'h80); send(8'h7F); send(8'h00);
    expect_state("off_nomatch", 4'hD, 32'h44434048, 32'hC8A0C8C8);
    drain();

    send(8'hB0); send(8'h7B); send(8'h00);
    expect_state("all_notes_off", 4'h0, 32'h44434048, 32'hC8A0C8C8);
    drain();
    send(8'h3C); send(8'h64);
    expect_state("cc_running", 4'h0, 32'h44434048, 32'hC8A0C8C8);
    drain();

    send(8'h90); send(8'h3C);
    pulse_reset();
    send(8'h64);
    expect_state("mid_reset", 4'h0, 32'h0, 32'h0);
    drain();

    send(8'h90); send(8'h3C); send(8'h64);
    expect_state("omni_ch0", 4'h1, 32'h0000003C, 32'h000000C8);
    drain();
    $display("txn ch1_ignore: gate=%h note=%h vel=%h", gate1, note1, vel1);
    check_value("ch1_ignore_gate", {28'd0, gate1}, 32'h0);
    check_value("ch1_ignore_note", note1, 32'h0);

    send(8'h91); send(8'h40); send(8'h64);
    expect_state("omni_ch1", 4'h3, 32'h0000403C, 32'h0000C8C8);
    drain();
    $display("txn ch1_accept: gate=%h note=%h vel=%h", gate1, note1, vel1);
    check_value("ch1_accept_gate", {28'd0, gate1}, 32'h1);
    check_value("ch1_accept_note", note1, 32'h00000040);
    check_value("ch1_accept_vel",  vel1,  32'h000000C8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
